// File: rtl/mxv_rx_pkg.sv
// Shared types and constants for the matrix-vector frame receiver.
// Frame layout on the wire: HDR LEN CMD payload TAIL.
package mxv_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_CMD,
        ST_PAYLOAD,
        ST_TAIL
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_CMD    = 3'd1,
        ERR_LEN    = 3'd2,
        ERR_TAIL   = 3'd3,
        ERR_PARITY = 3'd4,
        ERR_TMO    = 3'd5,
        ERR_SIZE   = 3'd6
    } err_e;

    localparam logic [7:0] HDR  = 8'hFE;
    localparam logic [7:0] TAIL = 8'hEF;

    localparam logic [7:0] CMD_SET_N  = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;
    localparam logic [7:0] CMD_LOAD_M = 8'h03;
    localparam logic [7:0] CMD_LOAD_V = 8'h04;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_SET_N) || (cmd == CMD_START) ||
               (cmd == CMD_LOAD_M) || (cmd == CMD_LOAD_V);
    endfunction

    // LEN covers CMD plus payload, so every legal frame has LEN >= 1.
    function automatic logic [7:0] exp_len(input logic [7:0] cmd, input logic [7:0] n);
        case (cmd)
            CMD_SET_N:  return 8'd2;
            CMD_START:  return 8'd1;
            CMD_LOAD_M: return 8'(n * n) + 8'd1;
            CMD_LOAD_V: return n + 8'd1;
            default:    return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/mxv_frame_receiver_if.sv
// UART Rx byte handshake: level-valid byte held until the consumer pulses rx_clear.
interface mxv_frame_receiver_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_parity_err;
    logic              rx_clear;

    modport master (output rx_data, output rx_valid, output rx_parity_err, input rx_clear);
    modport slave  (input rx_data, input rx_valid, input rx_parity_err, output rx_clear);
endinterface

// File: rtl/mxv_rx_timeout.sv
// Inter-byte timeout counter: counts while enabled, clears on clr_i,
// flags tmo_o for one cycle when the count reaches TMO_CYC-1.
module mxv_rx_timeout #(
    parameter int TMO_CYC = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tmo_o
);
    localparam int CW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i)
            cnt_d = '0;
        else if (cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tmo_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/mxv_frame_receiver.sv
// Framed command receiver for the matrix-vector engine (FE LEN CMD payload EF).
// Define MXV_RX_TIMEOUT_EN to abort partial frames after TMO_CYC idle cycles.
module mxv_frame_receiver
    import mxv_rx_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int MAX_N   = 8,
    parameter  int TMO_CYC = 50000,
    localparam int N_W     = $clog2(MAX_N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    mxv_frame_receiver_if.slave rx,
    output logic [N_W-1:0]     matrix_len,
    output logic [DATA_W-1:0]  mat_data,
    output logic               mat_push,
    output logic               mat_flush,
    output logic [DATA_W-1:0]  vec_data,
    output logic [N_W-1:0]     vec_addr,
    output logic               vec_wr,
    output logic               start,
    output logic               cmd_done,
    output logic [7:0]         cmd_code,
    output logic               frame_err,
    output logic [2:0]         err_code
);

    if (MAX_N * MAX_N + 1 > 255) begin : g_bad_max_n
        $error("MAX_N*MAX_N+1 must fit the 8-bit LEN field");
    end
    if (DATA_W < 8) begin : g_bad_data_w
        $error("DATA_W must be at least 8");
    end
    if (TMO_CYC < 2) begin : g_bad_tmo
        $error("TMO_CYC must be at least 2");
    end

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [N_W-1:0]     pend_q, pend_d;
    logic               pushed_q, pushed_d;
    logic               rx_clear_q;
    logic [DATA_W-1:0]  mat_data_q, mat_data_d;
    logic [DATA_W-1:0]  vec_data_q, vec_data_d;
    logic [N_W-1:0]     vec_addr_q, vec_addr_d;
    logic               push_q, push_d;
    logic               flush_q, flush_d;
    logic               vwr_q, vwr_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    err_e               err_code_q, err_code_d;

    logic               consume;
    logic [7:0]         b8;
    logic               abort;
    err_e               abort_code;

    assign consume = rx.rx_valid && !rx_clear_q;
    assign b8      = rx.rx_data[7:0];

`ifdef MXV_RX_TIMEOUT_EN
    logic tmo_hit;

    mxv_rx_timeout #(
        .TMO_CYC(TMO_CYC)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q != ST_IDLE),
        .clr_i (consume),
        .tmo_o (tmo_hit)
    );
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        cmd_d      = cmd_q;
        n_d        = n_q;
        pend_d     = pend_q;
        pushed_d   = pushed_q;
        mat_data_d = mat_data_q;
        vec_data_d = vec_data_q;
        vec_addr_d = vec_addr_q;
        cmd_code_d = cmd_code_q;
        err_code_d = err_code_q;
        push_d     = 1'b0;
        flush_d    = 1'b0;
        vwr_d      = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        if (consume) begin
            if (rx.rx_parity_err) begin
                // Parity errors outside a frame are simply dropped.
                if (state_q != ST_IDLE) begin
                    abort      = 1'b1;
                    abort_code = ERR_PARITY;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (b8 == HDR) begin
                            state_d    = ST_LEN;
                            err_code_d = ERR_NONE;
                        end
                    end
                    ST_LEN: begin
                        len_d   = b8;
                        state_d = ST_CMD;
                    end
                    ST_CMD: begin
                        cmd_d    = b8;
                        cnt_d    = 8'd0;
                        pushed_d = 1'b0;
                        if (!cmd_known(b8)) begin
                            abort      = 1'b1;
                            abort_code = ERR_CMD;
                        end else if ((b8 == CMD_LOAD_M || b8 == CMD_LOAD_V) && n_q == '0) begin
                            abort      = 1'b1;
                            abort_code = ERR_SIZE;
                        end else if (len_q != exp_len(b8, 8'(n_q))) begin
                            abort      = 1'b1;
                            abort_code = ERR_LEN;
                        end else begin
                            state_d = (len_q == 8'd1) ? ST_TAIL : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        cnt_d = cnt_q + 8'd1;
                        // Payload is LEN-1 bytes; cnt_q indexes the byte being taken now.
                        if (cnt_q + 8'd2 == len_q)
                            state_d = ST_TAIL;
                        case (cmd_q)
                            CMD_SET_N: begin
                                if (b8 == 8'd0 || int'(b8) > MAX_N) begin
                                    abort      = 1'b1;
                                    abort_code = ERR_SIZE;
                                end else begin
                                    pend_d = N_W'(b8);
                                end
                            end
                            CMD_LOAD_M: begin
                                mat_data_d = rx.rx_data;
                                push_d     = 1'b1;
                                pushed_d   = 1'b1;
                            end
                            CMD_LOAD_V: begin
                                vec_data_d = rx.rx_data;
                                vec_addr_d = N_W'(cnt_q);
                                vwr_d      = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    ST_TAIL: begin
                        if (b8 == TAIL) begin
                            state_d    = ST_IDLE;
                            done_d     = 1'b1;
                            cmd_code_d = cmd_q;
                            start_d    = (cmd_q == CMD_START);
                            if (cmd_q == CMD_SET_N)
                                n_d = pend_q;
                        end else begin
                            abort      = 1'b1;
                            abort_code = ERR_TAIL;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

`ifdef MXV_RX_TIMEOUT_EN
        if (tmo_hit) begin
            abort      = 1'b1;
            abort_code = ERR_TMO;
        end
`endif

        if (abort) begin
            state_d    = ST_IDLE;
            ferr_d     = 1'b1;
            err_code_d = abort_code;
            // pushed_q is only meaningful once CMD has been accepted for this frame.
            flush_d    = pushed_q && (cmd_q == CMD_LOAD_M) &&
                         (state_q == ST_PAYLOAD || state_q == ST_TAIL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            len_q      <= 8'd0;
            cmd_q      <= 8'd0;
            n_q        <= '0;
            pend_q     <= '0;
            pushed_q   <= 1'b0;
            rx_clear_q <= 1'b0;
            mat_data_q <= '0;
            vec_data_q <= '0;
            vec_addr_q <= '0;
            push_q     <= 1'b0;
            flush_q    <= 1'b0;
            vwr_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            cmd_code_q <= 8'd0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            cmd_q      <= cmd_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            pushed_q   <= pushed_d;
            rx_clear_q <= consume;
            mat_data_q <= mat_data_d;
            vec_data_q <= vec_data_d;
            vec_addr_q <= vec_addr_d;
            push_q     <= push_d;
            flush_q    <= flush_d;
            vwr_q      <= vwr_d;
            start_q    <= start_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            cmd_code_q <= cmd_code_d;
            err_code_q <= err_code_d;
        end
    end

    assign rx.rx_clear = rx_clear_q;
    assign matrix_len  = n_q;
    assign mat_data    = mat_data_q;
    assign mat_push    = push_q;
    assign mat_flush   = flush_q;
    assign vec_data    = vec_data_q;
    assign vec_addr    = vec_addr_q;
    assign vec_wr      = vwr_q;
    assign start       = start_q;
    assign cmd_done    = done_q;
    assign cmd_code    = cmd_code_q;
    assign frame_err   = ferr_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_mxv_frame_receiver.sv
// Directed bench for mxv_frame_receiver: frame table plus timeout and mid-frame reset sequences.
module tb_mxv_frame_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] matrix_len;
    logic [7:0] mat_data;
    logic       mat_push;
    logic       mat_flush;
    logic [7:0] vec_data;
    logic [3:0] vec_addr;
    logic       vec_wr;
    logic       start;
    logic       cmd_done;
    logic [7:0] cmd_code;
    logic       frame_err;
    logic [2:0] err_code;

    mxv_frame_receiver_if #(.DATA_W(8)) rxif ();

    mxv_frame_receiver #(
        .DATA_W (8),
        .MAX_N  (8),
        .TMO_CYC(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rxif.slave),
        .matrix_len(matrix_len),
        .mat_data  (mat_data),
        .mat_push  (mat_push),
        .mat_flush (mat_flush),
        .vec_data  (vec_data),
        .vec_addr  (vec_addr),
        .vec_wr    (vec_wr),
        .start     (start),
        .cmd_done  (cmd_done),
        .cmd_code  (cmd_code),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event monitor: the only writer of these counters and logs.
    int         n_clr = 0, n_done = 0, n_ferr = 0, n_start = 0, n_flush = 0;
    logic [7:0] mat_log[$];
    logic [7:0] vdat_log[$];
    logic [3:0] vadr_log[$];

    always @(negedge clk) begin
        if (rxif.rx_clear) n_clr++;
        if (cmd_done)      n_done++;
        if (frame_err)     n_ferr++;
        if (start)         n_start++;
        if (mat_flush)     n_flush++;
        if (mat_push)      mat_log.push_back(mat_data);
        if (vec_wr) begin
            vdat_log.push_back(vec_data);
            vadr_log.push_back(vec_addr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit par);
        int k;
        @(negedge clk);
        rxif.rx_data       = b;
        rxif.rx_valid      = 1'b1;
        rxif.rx_parity_err = par;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!rxif.rx_clear && k < 20);
        if (!rxif.rx_clear) begin
            checks++;
            errors++;
            $display("FAIL rx_clear_wait actual=0 required=1");
        end
        rxif.rx_valid      = 1'b0;
        rxif.rx_parity_err = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return {22'd0, rxif.rx_clear, mat_push, mat_flush, vec_wr, start, cmd_done, frame_err,
                matrix_len, mat_data, vec_data, vec_addr, cmd_code, err_code};
    endfunction

    typedef struct {
        int               nb;
        logic [0:15][7:0] b;
        int               par;
        int               mlen, done, ferr, err, code, push, vwr, strt, flush;
    } vec_t;

    vec_t vt[$];

    // Bytes are given left-to-right as one hex literal of nb bytes.
    task automatic add(input int nb, input logic [127:0] v, input int par,
                       input int mlen, input int done, input int ferr, input int err,
                       input int code, input int push, input int vwr, input int strt,
                       input int flush);
        vec_t r;
        r.nb = nb;  r.b = v << (8 * (16 - nb));  r.par = par;
        r.mlen = mlen; r.done = done; r.ferr = ferr; r.err = err; r.code = code;
        r.push = push; r.vwr = vwr; r.strt = strt; r.flush = flush;
        vt.push_back(r);
    endtask

    int         c_clr, c_done, c_ferr, c_start, c_flush, c_mat, c_vec;
    int         exp_n;
    logic [7:0] ld_len;

    initial begin
        //   nb  bytes                                 par mlen done ferr err code push vwr st fl
        add( 4, 128'hFE0103EF,                          -1, 0, 0, 1, 6, 8'h00, 0, 0, 0, 0);
        add( 7, 128'h55AAFE020103EF,                    -1, 3, 1, 0, 0, 8'h01, 0, 0, 0, 0);
        add(13, 128'hFE0A03A1A2A3A4A5A6A7A8A9EF,        -1, 3, 1, 0, 0, 8'h03, 9, 0, 0, 0);
        add( 7, 128'hFE040411223FEF & 128'h0 | 128'hFE0404112233EF,
                                                        -1, 3, 1, 0, 0, 8'h04, 0, 3, 0, 0);
        add( 4, 128'hFE0102EF,                          -1, 3, 1, 0, 0, 8'h02, 0, 0, 1, 0);
        add( 8, 128'hFE0A03B1B2B3B4C5,                   7, 3, 0, 1, 4, 8'h02, 4, 0, 0, 1);
        add( 5, 128'hFE030105EF,                        -1, 3, 0, 1, 2, 8'h02, 0, 0, 0, 0);
        add( 5, 128'hFE020109EF,                        -1, 3, 0, 1, 6, 8'h02, 0, 0, 0, 0);
        add( 4, 128'hFE0107EF,                          -1, 3, 0, 1, 1, 8'h02, 0, 0, 0, 0);
        add( 4, 128'hFE0102AA,                          -1, 3, 0, 1, 3, 8'h02, 0, 0, 0, 0);
        add( 5, 128'hFE020100EF,                        -1, 3, 0, 1, 6, 8'h02, 0, 0, 0, 0);
        add( 5, 128'hFE020108EF,                        -1, 8, 1, 0, 0, 8'h01, 0, 0, 0, 0);
        add( 5, 128'hFE020411EF,                        -1, 8, 0, 1, 2, 8'h01, 0, 0, 0, 0);
        add( 5, 128'hFE020102EF,                        -1, 2, 1, 0, 0, 8'h01, 0, 0, 0, 0);
        add( 8, 128'hFE050301020304EF,                  -1, 2, 1, 0, 0, 8'h03, 4, 0, 0, 0);
        add( 5, 128'hFE020305EF,                        -1, 2, 0, 1, 2, 8'h03, 0, 0, 0, 0);
        add( 8, 128'hFE05030102030455,                  -1, 2, 0, 1, 3, 8'h03, 4, 0, 0, 1);
        add( 6, 128'hFE0304FEEEEF,                      -1, 2, 1, 0, 0, 8'h04, 0, 2, 0, 0);
        add( 5, 128'h5AFE0102EF,                         0, 2, 1, 0, 0, 8'h02, 0, 0, 1, 0);

        reset              = 1'b1;
        rxif.rx_data       = 8'h00;
        rxif.rx_valid      = 1'b0;
        rxif.rx_parity_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;

        foreach (vt[i]) begin
            c_clr = n_clr; c_done = n_done; c_ferr = n_ferr; c_start = n_start;
            c_flush = n_flush; c_mat = mat_log.size(); c_vec = vdat_log.size();
            for (int j = 0; j < vt[i].nb; j++)
                send(vt[i].b[j], j == vt[i].par);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_clr", i),   n_clr - c_clr,     vt[i].nb);
            chk($sformatf("v%0d_mlen", i),  matrix_len,        vt[i].mlen);
            chk($sformatf("v%0d_done", i),  n_done - c_done,   vt[i].done);
            chk($sformatf("v%0d_ferr", i),  n_ferr - c_ferr,   vt[i].ferr);
            chk($sformatf("v%0d_err", i),   err_code,          vt[i].err);
            chk($sformatf("v%0d_code", i),  cmd_code,          vt[i].code);
            chk($sformatf("v%0d_push", i),  mat_log.size() - c_mat,  vt[i].push);
            chk($sformatf("v%0d_vwr", i),   vdat_log.size() - c_vec, vt[i].vwr);
            chk($sformatf("v%0d_start", i), n_start - c_start, vt[i].strt);
            chk($sformatf("v%0d_flush", i), n_flush - c_flush, vt[i].flush);
            // Payload bytes start at frame offset 3 for every frame in the table.
            for (int k = c_mat; k < mat_log.size() && k - c_mat < 12; k++)
                chk($sformatf("v%0d_mdat%0d", i, k - c_mat), mat_log[k], vt[i].b[3 + k - c_mat]);
            for (int k = c_vec; k < vdat_log.size() && k - c_vec < 12; k++) begin
                chk($sformatf("v%0d_vdat%0d", i, k - c_vec), vdat_log[k], vt[i].b[3 + k - c_vec]);
                chk($sformatf("v%0d_vadr%0d", i, k - c_vec), vadr_log[k], k - c_vec);
            end
        end

        // Stall mid-frame after LEN.
        c_ferr = n_ferr; c_done = n_done;
        send(8'hFE, 1'b0);
        send(8'h02, 1'b0);
        repeat (80) @(negedge clk);
`ifdef MXV_RX_TIMEOUT_EN
        chk("tmo_ferr", n_ferr - c_ferr, 1);
        chk("tmo_err", err_code, 5);
        send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'hEF, 1'b0);
        repeat (3) @(negedge clk);
        chk("tmo_late_done", n_done - c_done, 0);
        chk("tmo_late_mlen", matrix_len, 2);
        exp_n = 2;
`else
        chk("stall_ferr", n_ferr - c_ferr, 0);
        send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'hEF, 1'b0);
        repeat (3) @(negedge clk);
        chk("stall_done", n_done - c_done, 1);
        chk("stall_mlen", matrix_len, 3);
        chk("stall_err", err_code, 0);
        exp_n = 3;
`endif

        // Reset in the middle of a matrix load.
        ld_len = 8'(exp_n * exp_n + 1);
        c_mat  = mat_log.size();
        send(8'hFE, 1'b0); send(ld_len, 1'b0); send(8'h03, 1'b0); send(8'h01, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_rst_push", mat_log.size() - c_mat, 1);
        chk("pre_rst_mlen", matrix_len, exp_n);
        rxif.rx_data  = 8'h02;
        rxif.rx_valid = 1'b1;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_outputs", all_outs(), 64'd0);
        @(negedge clk);
        reset         = 1'b0;
        rxif.rx_valid = 1'b0;

        c_done = n_done; c_ferr = n_ferr;
        send(8'hFE, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0); send(8'h05, 1'b0); send(8'hEF, 1'b0);
        repeat (3) @(negedge clk);
        chk("post_rst_mlen", matrix_len, 5);
        chk("post_rst_done", n_done - c_done, 1);
        chk("post_rst_ferr", n_ferr - c_ferr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
